// File: rtl/pd_capture_pkg.sv
// rtl/pd_capture_pkg.sv - shared constants and types for the capture sequencer
package pd_capture_pkg;

  localparam logic [7:0] SR_CAP_CTRL = 8'd139;
  localparam logic [7:0] SR_CAP_LEN  = 8'd140;
  localparam logic [7:0] SR_HOLDOFF  = 8'd141;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_ONE_SHOT_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_HOLDOFF
  } cap_state_t;

  // A zero-length frame makes no sense; treat it as a single-beat frame.
  function automatic logic [15:0] eff_len(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/pd_cap_out_reg.sv
// rtl/pd_cap_out_reg.sv - one-deep valid/ready output register carrying {tlast, tdata}
module pd_cap_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  output logic             o_can_load
);

  logic             r_valid;
  logic [WIDTH:0]   r_beat;

  // Hold the beat until taken; a load in the same cycle as a handshake replaces it with no bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= {i_tlast, i_tdata};
    end else if (i_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_can_load = ~r_valid | i_tready;
  assign o_tvalid   = r_valid;
  assign o_tlast    = r_beat[WIDTH];
  assign o_tdata    = r_beat[WIDTH-1:0];

endmodule

// File: rtl/pd_capture_ctrl.sv
// rtl/pd_capture_ctrl.sv - detection-triggered fixed-length frame capture sequencer
module pd_capture_ctrl
  import pd_capture_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tdetect,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic [15:0]      pkt_count,
  output logic [15:0]      drop_count
);

  cap_state_t  r_state;
  cap_state_t  w_state_next;
  logic [1:0]  r_ctrl;
  logic [15:0] r_len;
  logic [15:0] r_holdoff;
  logic [15:0] r_len_lat;
  logic [15:0] r_cnt;
  logic [15:0] r_hcnt;
  logic [15:0] r_pkt_count;
  logic [15:0] r_drop_count;

  logic [15:0] w_len_eff;
  logic        w_en;
  logic        w_one_shot;
  logic        w_in_ready;
  logic        w_out_can_load;
  logic        w_accept;
  logic        w_load;
  logic        w_load_last;
  logic        w_trigger;
  logic        w_pkt_inc;
  logic        w_drop_inc;
  logic        w_disarm;
  logic        w_unused_set;

  assign w_en         = r_ctrl[CTRL_EN_BIT];
  assign w_one_shot   = r_ctrl[CTRL_ONE_SHOT_BIT];
  assign w_len_eff    = eff_len(r_len);
  assign w_accept     = i_tvalid & w_in_ready;
  assign w_unused_set = ^set_data[31:16];

  // Settings decode; a host write lands after the one-shot auto-disarm so the host wins a tie.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_ctrl    <= '0;
      r_len     <= '0;
      r_holdoff <= '0;
    end else begin
      if (w_disarm && !clear) r_ctrl[CTRL_EN_BIT] <= 1'b0;
      if (set_stb) begin
        case (set_addr)
          SR_CAP_CTRL: r_ctrl    <= set_data[1:0];
          SR_CAP_LEN:  r_len     <= set_data[15:0];
          SR_HOLDOFF:  r_holdoff <= set_data[15:0];
          default: ;
        endcase
      end
    end
  end

  // State register; clear restarts the sequencer without touching the settings.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst)     r_state <= ST_IDLE;
    else if (clear) r_state <= w_en ? ST_ARMED : ST_IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state, input ready and output-load decisions.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_load       = 1'b0;
    w_load_last  = 1'b0;
    w_trigger    = 1'b0;
    w_pkt_inc    = 1'b0;
    w_drop_inc   = 1'b0;
    w_disarm     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (w_en) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        w_in_ready = w_out_can_load;
        if (i_tvalid && w_out_can_load && i_tdetect) begin
          w_load    = 1'b1;
          w_trigger = 1'b1;
          if (w_len_eff == 16'd1) begin
            w_load_last  = 1'b1;
            w_pkt_inc    = 1'b1;
            w_state_next = ST_HOLDOFF;
          end else begin
            w_state_next = ST_CAPTURE;
          end
        end else if (!w_en) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        w_in_ready = w_out_can_load;
        if (i_tvalid && w_out_can_load) begin
          w_load     = 1'b1;
          w_drop_inc = i_tdetect;
          if (r_cnt == (r_len_lat - 16'd1)) begin
            w_load_last  = 1'b1;
            w_pkt_inc    = 1'b1;
            w_state_next = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        w_in_ready = 1'b1;
        w_drop_inc = i_tvalid & i_tdetect;
        if ((r_holdoff == 16'd0) || (i_tvalid && (r_hcnt == (r_holdoff - 16'd1)))) begin
          if (w_one_shot || !w_en) begin
            w_state_next = ST_IDLE;
            w_disarm     = w_one_shot;
          end else begin
            w_state_next = ST_ARMED;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Beat counters and statistics; frame length is latched at trigger so mid-frame writes wait.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_len_lat    <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_trigger) begin
        r_cnt     <= 16'd1;
        r_len_lat <= w_len_eff;
      end else if ((r_state == ST_CAPTURE) && w_accept) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (r_state != ST_HOLDOFF) r_hcnt <= '0;
      else if (w_accept)         r_hcnt <= r_hcnt + 16'd1;
      if (w_pkt_inc) r_pkt_count <= r_pkt_count + 16'd1;
      if (w_drop_inc && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  pd_cap_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .i_clk      (ce_clk),
    .i_rst      (ce_rst),
    .i_clear    (clear),
    .i_load     (w_load),
    .i_tdata    (i_tdata),
    .i_tlast    (w_load_last),
    .i_tready   (o_tready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_can_load (w_out_can_load)
  );

  assign i_tready   = w_in_ready;
  assign busy       = (r_state == ST_CAPTURE) || (r_state == ST_HOLDOFF);
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;

endmodule
